// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 16x oversampling, majority-vote bit sampling, optional parity,
// 1 or 2 stop bits, single-entry output register with valid/ready handshake.
module uart_rx_cfg #(
  parameter int unsigned CLK_FREQ  = 50000000,
  parameter int unsigned BAUD      = 115200,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 overrun
);

  localparam int unsigned DivRaw = CLK_FREQ / (BAUD * 16);
  localparam int unsigned Div    = (DivRaw > 0) ? DivRaw : 1;
  localparam int unsigned DivW   = (Div > 1) ? $clog2(Div) : 1;

  typedef enum logic [2:0] {StIdle, StStart, StData, StPar, StStop} state_e;

  state_e                 state_q, state_d;
  logic [DivW-1:0]        div_q, div_d;
  logic [1:0]             sync_q;
  logic [3:0]             tick_cnt_q, tick_cnt_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [1:0]             smp_q, smp_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_q, par_d;
  logic                   fe_acc_q, fe_acc_d;
  logic                   st0_low_q, st0_low_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   parity_err_q, parity_err_d;
  logic                   frame_err_q, frame_err_d;
  logic                   break_q, break_d;
  logic                   overrun_q, overrun_d;

  logic tick, rxs, maj, mid, last, done;
  logic pe_new, fe_new, st0_low, brk_new;

  assign rxs  = sync_q[1];
  assign tick = (div_q == DivW'(Div - 1));
  assign div_d = tick ? '0 : div_q + DivW'(1);
  assign maj  = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxs) | (smp_q[1] & rxs);
  assign mid  = tick && (tick_cnt_q == 4'd9);
  assign last = tick && (tick_cnt_q == 4'd15);

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    smp_d      = smp_q;
    shift_d    = shift_q;
    par_d      = par_q;
    fe_acc_d   = fe_acc_q;
    st0_low_d  = st0_low_q;
    done       = 1'b0;

    if (state_q != StIdle && tick) begin
      tick_cnt_d = tick_cnt_q + 4'd1;
      if (tick_cnt_q == 4'd7) smp_d[0] = rxs;
      if (tick_cnt_q == 4'd8) smp_d[1] = rxs;
    end

    case (state_q)
      StIdle: begin
        if (!rxs) begin
          state_d    = StStart;
          tick_cnt_d = '0;
          fe_acc_d   = 1'b0;
        end
      end
      StStart: begin
        if (mid && maj) begin
          state_d = StIdle;
        end else if (last) begin
          state_d   = StData;
          bit_cnt_d = '0;
        end
      end
      StData: begin
        if (mid) shift_d = {maj, shift_q[DATA_BITS-1:1]};
        if (last) begin
          if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
            bit_cnt_d = '0;
            state_d   = (PARITY != 0) ? StPar : StStop;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      StPar: begin
        if (mid) par_d = maj;
        if (last) state_d = StStop;
      end
      StStop: begin
        // Leave at the final stop-bit mid-point so a back-to-back start edge is not missed.
        if (mid) begin
          if (!maj) fe_acc_d = 1'b1;
          if (bit_cnt_q == 4'd0) st0_low_d = ~maj;
          if (bit_cnt_q == 4'(STOP_BITS - 1)) begin
            state_d = StIdle;
            done    = 1'b1;
          end
        end else if (last) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Frame status as seen at completion, folding in the stop sample taken this cycle.
  always_comb begin
    fe_new  = fe_acc_q | ~maj;
    st0_low = (bit_cnt_q == 4'd0) ? ~maj : st0_low_q;
    if (PARITY == 1)      pe_new = ~(^shift_q ^ par_q);
    else if (PARITY == 2) pe_new = ^shift_q ^ par_q;
    else                  pe_new = 1'b0;
    brk_new = (shift_q == '0) && ((PARITY == 0) || !par_q) && st0_low;
  end

  always_comb begin
    data_d       = data_q;
    valid_d      = valid_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    break_d      = 1'b0;
    overrun_d    = 1'b0;
    if (done) begin
      break_d = brk_new;
      if (!valid_q || rx_ready) begin
        data_d       = shift_q;
        valid_d      = 1'b1;
        parity_err_d = pe_new;
        frame_err_d  = fe_new;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && rx_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      div_q        <= '0;
      sync_q       <= 2'b11;
      tick_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      smp_q        <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      fe_acc_q     <= 1'b0;
      st0_low_q    <= 1'b0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      break_q      <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      sync_q       <= {sync_q[0], rx};
      tick_cnt_q   <= tick_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      smp_q        <= smp_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      fe_acc_q     <= fe_acc_d;
      st0_low_q    <= st0_low_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      break_q      <= break_d;
      overrun_q    <= overrun_d;
    end
  end

  assign rx_data    = data_q;
  assign rx_valid   = valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign break_det  = break_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: three instances (8N1, 8E1, 7N2) sharing clock and reset.
module tb_uart_rx_cfg;

  localparam int Bit = 432;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx0 = 1'b1, rx1 = 1'b1, rx2 = 1'b1;
  logic rdy0 = 1'b1, rdy1 = 1'b1, rdy2 = 1'b1;
  logic [7:0] rd0, rd1;
  logic [6:0] rd2;
  logic v0, v1, v2, pe0, pe1, pe2, fe0, fe1, fe2, bk0, bk1, bk2, ov0, ov1, ov2;

  int checks = 0;
  int errors = 0;

  int hs0 = 0, hi0 = 0, brk0 = 0, ovr0 = 0;
  int hs1 = 0, brk1 = 0, ovr1 = 0;
  int hs2 = 0, brk2 = 0, ovr2 = 0;
  logic [8:0] ld0 = '0, ld1 = '0, ld2 = '0;
  logic lpe0 = 1'b0, lfe0 = 1'b0, lpe1 = 1'b0, lfe1 = 1'b0, lpe2 = 1'b0, lfe2 = 1'b0;

  always #5 clk = ~clk;

  uart_rx_cfg u_dut0 (
    .clk(clk), .rst_n(rst_n), .rx(rx0), .rx_data(rd0), .rx_valid(v0), .rx_ready(rdy0),
    .parity_err(pe0), .frame_err(fe0), .break_det(bk0), .overrun(ov0)
  );

  uart_rx_cfg #(.PARITY(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .rx(rx1), .rx_data(rd1), .rx_valid(v1), .rx_ready(rdy1),
    .parity_err(pe1), .frame_err(fe1), .break_det(bk1), .overrun(ov1)
  );

  uart_rx_cfg #(.DATA_BITS(7), .STOP_BITS(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .rx(rx2), .rx_data(rd2), .rx_valid(v2), .rx_ready(rdy2),
    .parity_err(pe2), .frame_err(fe2), .break_det(bk2), .overrun(ov2)
  );

  always @(posedge clk) begin
    if (v0 && rdy0) begin
      hs0 <= hs0 + 1; ld0 <= {1'b0, rd0}; lpe0 <= pe0; lfe0 <= fe0;
    end
    if (v0)  hi0  <= hi0 + 1;
    if (bk0) brk0 <= brk0 + 1;
    if (ov0) ovr0 <= ovr0 + 1;
    if (v1 && rdy1) begin
      hs1 <= hs1 + 1; ld1 <= {1'b0, rd1}; lpe1 <= pe1; lfe1 <= fe1;
    end
    if (bk1) brk1 <= brk1 + 1;
    if (ov1) ovr1 <= ovr1 + 1;
    if (v2 && rdy2) begin
      hs2 <= hs2 + 1; ld2 <= {2'b0, rd2}; lpe2 <= pe2; lfe2 <= fe2;
    end
    if (bk2) brk2 <= brk2 + 1;
    if (ov2) ovr2 <= ovr2 + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_line(input int sel, input logic v);
    case (sel)
      0: rx0 = v;
      1: rx1 = v;
      default: rx2 = v;
    endcase
  endtask

  task automatic send(input int sel, input logic [8:0] data, input int nbits, input bit has_par,
                      input logic par, input int nstop, input logic stopv);
    set_line(sel, 1'b0);
    wait_clks(Bit);
    for (int i = 0; i < nbits; i++) begin
      set_line(sel, data[i]);
      wait_clks(Bit);
    end
    if (has_par) begin
      set_line(sel, par);
      wait_clks(Bit);
    end
    for (int i = 0; i < nstop; i++) begin
      set_line(sel, (i == 0) ? stopv : 1'b1);
      wait_clks(Bit);
    end
    set_line(sel, 1'b1);
    wait_clks(Bit);
  endtask

  int h, b, o, hh;

  initial begin
    // Reset state
    wait_clks(3);
    check("rst_valid", 32'(v0), 32'd0);
    check("rst_data", 32'(rd0), 32'd0);
    check("rst_perr", 32'(pe0), 32'd0);
    check("rst_ferr", 32'(fe0), 32'd0);
    check("rst_break", 32'(bk0), 32'd0);
    check("rst_overrun", 32'(ov0), 32'd0);
    rst_n = 1'b1;
    wait_clks(Bit);

    // 8N1 0xA5 with ready high: one-cycle valid pulse
    h = hs0; hh = hi0; o = ovr0;
    send(0, 9'h0A5, 8, 1'b0, 1'b0, 1, 1'b1);
    check("a5_hs", 32'(hs0 - h), 32'd1);
    check("a5_hi_cycles", 32'(hi0 - hh), 32'd1);
    check("a5_data", 32'(ld0), 32'h0A5);
    check("a5_perr", 32'(lpe0), 32'd0);
    check("a5_ferr", 32'(lfe0), 32'd0);
    check("a5_ovr", 32'(ovr0 - o), 32'd0);
    check("a5_valid_low", 32'(v0), 32'd0);

    // Even parity on 0x37 (five 1s): bit 0 is wrong, bit 1 is right
    h = hs1;
    send(1, 9'h037, 8, 1'b1, 1'b0, 1, 1'b1);
    check("par_bad_hs", 32'(hs1 - h), 32'd1);
    check("par_bad_data", 32'(ld1), 32'h037);
    check("par_bad_perr", 32'(lpe1), 32'd1);
    send(1, 9'h037, 8, 1'b1, 1'b1, 1, 1'b1);
    check("par_ok_data", 32'(ld1), 32'h037);
    check("par_ok_perr", 32'(lpe1), 32'd0);
    check("par_ok_ferr", 32'(lfe1), 32'd0);

    // Framing error without break, then a genuine break
    b = brk0; h = hs0;
    send(0, 9'h05A, 8, 1'b0, 1'b0, 1, 1'b0);
    check("fe_data", 32'(ld0), 32'h05A);
    check("fe_ferr", 32'(lfe0), 32'd1);
    check("fe_nobreak", 32'(brk0 - b), 32'd0);
    send(0, 9'h000, 8, 1'b0, 1'b0, 1, 1'b0);
    check("brk_pulse", 32'(brk0 - b), 32'd1);
    check("brk_ferr", 32'(lfe0), 32'd1);
    check("brk_data", 32'(ld0), 32'h000);
    check("brk_hs", 32'(hs0 - h), 32'd2);

    // Short glitch is a false start; next frame is clean
    h = hs0;
    rx0 = 1'b0;
    wait_clks(108);
    rx0 = 1'b1;
    wait_clks(2 * Bit);
    check("glitch_none", 32'(hs0 - h), 32'd0);
    send(0, 9'h03C, 8, 1'b0, 1'b0, 1, 1'b1);
    check("post_glitch_data", 32'(ld0), 32'h03C);
    check("post_glitch_ferr", 32'(lfe0), 32'd0);

    // Overrun: second frame dropped while first is held
    rdy0 = 1'b0; o = ovr0; h = hs0;
    send(0, 9'h011, 8, 1'b0, 1'b0, 1, 1'b1);
    send(0, 9'h022, 8, 1'b0, 1'b0, 1, 1'b1);
    check("ovr_valid", 32'(v0), 32'd1);
    check("ovr_held", 32'(rd0), 32'h011);
    check("ovr_pulse", 32'(ovr0 - o), 32'd1);
    rdy0 = 1'b1;
    wait_clks(1);
    check("ovr_drain_valid", 32'(v0), 32'd0);
    check("ovr_drain_hs", 32'(hs0 - h), 32'd1);
    check("ovr_drain_data", 32'(ld0), 32'h011);

    // Reset during data bit 3, then a fresh frame
    h = hs0;
    rx0 = 1'b0;
    wait_clks(4 * Bit + 200);
    rst_n = 1'b0;
    rx0 = 1'b1;
    wait_clks(5);
    check("mid_rst_valid", 32'(v0), 32'd0);
    check("mid_rst_data", 32'(rd0), 32'd0);
    rst_n = 1'b1;
    wait_clks(2 * Bit);
    check("mid_rst_no_out", 32'(hs0 - h), 32'd0);
    send(0, 9'h0C3, 8, 1'b0, 1'b0, 1, 1'b1);
    check("after_rst_data", 32'(ld0), 32'h0C3);
    check("after_rst_hs", 32'(hs0 - h), 32'd1);

    // Same on the 7-bit, 2-stop instance
    h = hs2;
    rx2 = 1'b0;
    wait_clks(4 * Bit + 200);
    rst_n = 1'b0;
    rx2 = 1'b1;
    wait_clks(5);
    check("d7_rst_valid", 32'(v2), 32'd0);
    rst_n = 1'b1;
    wait_clks(2 * Bit);
    check("d7_no_out", 32'(hs2 - h), 32'd0);
    send(2, 9'h055, 7, 1'b0, 1'b0, 2, 1'b1);
    check("d7_data", 32'(ld2), 32'h055);
    check("d7_hs", 32'(hs2 - h), 32'd1);
    check("d7_ferr", 32'(lfe2), 32'd0);
    check("d7_perr", 32'(lpe2), 32'd0);

    check("d0_perr_none", 32'(lpe0), 32'd0);
    check("d1_no_break", 32'(brk1), 32'd0);
    check("d1_no_ovr", 32'(ovr1), 32'd0);
    check("d2_no_break", 32'(brk2), 32'd0);
    check("d2_no_ovr", 32'(ovr2), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 The block SHALL provide parameter CLK_FREQ, 50000000, system clock frequency in Hz.
REQ-002 The block SHALL provide parameter BAUD, 115200, line rate in bits/s.
REQ-003 The block SHALL provide parameter DATA_BITS, 8, data bits per frame, legal range 5..9.
REQ-004 The block SHALL provide parameter PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
REQ-005 The block SHALL provide parameter STOP_BITS, 1, stop bits per frame, legal values 1 or 2.
REQ-006 The block SHALL have port clk, input, 1, single system clock; all logic rising-edge.
REQ-007 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 The block SHALL have port rx, input, 1, asynchronous serial line; idles high.
REQ-009 The block SHALL have port rx_data, output, DATA_BITS, received word, LSB received first.
REQ-010 The block SHALL have port rx_valid, output, 1, rx_data and its error flags are valid; held until consumed.
REQ-011 The block SHALL have port rx_ready, input, 1, consumer accepts the word when rx_valid && rx_ready.
REQ-012 The block SHALL have port parity_err, output, 1, parity mismatch on the held word; 0 when PARITY = 0.
REQ-013 The block SHALL have port frame_err, output, 1, a stop bit sampled low on the held word.
REQ-014 The block SHALL have port break_det, output, 1, one-cycle pulse when a frame has all data bits 0, parity 0 if present, and first stop 0.
REQ-015 The block SHALL have port overrun, output, 1, one-cycle pulse when a completed frame is dropped.

Function
REQ-016 Oversample tick SHALL be a one-cycle pulse every DIV = CLK_FREQ/(BAUD*16) clocks (integer division); at defaults DIV = 27, bit = 432 clocks.
REQ-017 The tick counter SHALL free-run; it is not restarted at the start edge, giving +/-1 tick start-edge uncertainty.
REQ-018 rx SHALL pass through a 2-flop synchronizer with both flops reset to 1; all logic uses the synchronized value rxs.
REQ-019 FSM states SHALL be IDLE, START, DATA, PAR, STOP; a 4-bit tick counter and a bit counter SHALL be used.
REQ-020 IDLE -> START on rxs = 0; tick counter cleared.
REQ-021 In START, the line SHALL be sampled on ticks 7, 8 and 9, and bit value = majority of the three samples (same rule in every state).
REQ-022 In START, majority 1 at tick 9 SHALL be a false start -> IDLE with no output change; majority 0 SHALL wait until tick 15 -> DATA.
REQ-023 DATA SHALL capture DATA_BITS bits, one per 16 ticks, LSB first; after the last bit go to PAR if PARITY != 0, else STOP.
REQ-024 PAR SHALL check the parity bit: odd requires an odd count of 1s over data plus parity; even requires an even count.
REQ-025 STOP SHALL sample each stop bit at mid-bit; any low sample sets frame_err; after the final stop-bit majority (tick 9) -> IDLE immediately, without waiting for the end of the bit.
REQ-026 On frame completion with rx_valid = 0, the next cycle SHALL load rx_data, parity_err and frame_err, and set rx_valid = 1.
REQ-027 On frame completion with rx_valid = 1 and rx_ready = 0, the new frame SHALL be discarded, overrun SHALL pulse one cycle, and held data SHALL be unchanged.
REQ-028 Completion in the same cycle as a rx_valid && rx_ready handshake SHALL load the new frame, with rx_valid remaining 1 and no overrun.
REQ-029 rx_valid && rx_ready with no completion SHALL clear rx_valid on the next edge.
REQ-030 break_det SHALL pulse together with the completion cycle, regardless of the overrun outcome; a broken frame SHALL still be delivered with frame_err = 1.
REQ-031 The FSM SHALL accept a new start edge in the cycle after returning to IDLE, so back-to-back frames are received.

Reset
REQ-032 rst_n low SHALL force, asynchronously: state IDLE; counters 0; synchronizer 1; rx_data 0; rx_valid, parity_err, frame_err, break_det and overrun all 0.
REQ-033 Reset asserted mid-frame SHALL abandon the frame with no partial output.
REQ-034 After release, the first falling edge on rx SHALL start a fresh frame.

Verification (defaults unless stated; bit = 432 clocks)
REQ-035 Drive 8N1 frame 0xA5 with rx_ready = 1 -> rx_valid pulses one cycle, rx_data = 0xA5, parity_err = 0, frame_err = 0, overrun = 0.
REQ-036 With PARITY = 2, drive 0x37 with parity bit 0 -> rx_data = 0x37, parity_err = 1; resend with parity bit 1 -> parity_err = 0.
REQ-037 Drive 0x5A with stop bit 0 -> frame_err = 1 and break_det = 0; drive all-zero data with stop 0 -> break_det pulses, frame_err = 1, rx_data = 0x00.
REQ-038 Pulse rx low for 108 clocks -> no rx_valid; a following 0x3C frame is received correctly.
REQ-039 With rx_ready = 0, send 0x11 then 0x22 -> rx_data stays 0x11 and overrun pulses once; raise rx_ready -> rx_valid drops the next cycle.
REQ-040 Assert rst_n low during data bit 3 of a frame, release, then send 0xC3 -> no output from the aborted frame, rx_data = 0xC3; repeat with DATA_BITS = 7, STOP_BITS = 2 sending 0x55 -> rx_data = 0x55.
